// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: one bit per cycle, shift-add multiply and
// restoring divide, with signed/unsigned modes, cancel and divide-by-zero flag.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic               is_div_q, is_div_d;
   logic               res_neg_q, res_neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q, acc_d;         // product / {remainder, quotient}
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               div0_q, div0_d;

   logic               op_signed;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign busy = busy_q;
   assign done = done_q;
   assign div0 = div0_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

   // Datapath: operand magnitudes, one multiply/divide step, sign correction
   always_comb begin
      op_signed = ~op[0];
      a_mag     = (op_signed && a[WIDTH-1]) ? ('0 - a) : a;
      b_mag     = (op_signed && b[WIDTH-1]) ? ('0 - b) : b;

      // Add-then-shift: the carry out of the add becomes the new MSB
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

      // Restoring step on {remainder, next dividend bit}
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];

      prod_fix  = res_neg_q ? ('0 - acc_q) : acc_q;
      quot_fix  = res_neg_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      rem_fix   = rem_neg_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
   end

   // Next-state and register updates for the IDLE/RUN/FIX/DONE sequence
   always_comb begin
      state_d   = state_q;
      is_div_d  = is_div_q;
      res_neg_d = res_neg_q;
      rem_neg_d = rem_neg_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      div0_d    = div0_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               is_div_d  = op[1];
               res_neg_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               rem_neg_d = op_signed & op[1] & a[WIDTH-1];
               div0_d    = 1'b0;
               cnt_d     = CW'(WIDTH);
               if (op[1]) begin
                  opnd_d = b_mag;
                  acc_d  = {{WIDTH{1'b0}}, a_mag};
               end else begin
                  opnd_d = a_mag;
                  acc_d  = {{WIDTH{1'b0}}, b_mag};
               end
               if (op[1] && (b == '0)) begin
                  div0_d  = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               if (is_div_q) begin
                  acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
               end else begin
                  acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         is_div_q  <= 1'b0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_div_q  <= is_div_d;
         res_neg_q <= res_neg_d;
         rem_neg_q <= rem_neg_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         div0_q    <= div0_d;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit vector table plus cancel, reset and
// 8-bit sequences.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        start32 = 1'b0, cancel32 = 1'b0;
   logic [1:0]  op32 = 2'b00;
   logic [31:0] a32 = '0, b32 = '0;
   logic        busy32, done32, div032;
   logic [31:0] hi32, lo32;

   logic        start8 = 1'b0, cancel8 = 1'b0;
   logic [1:0]  op8 = 2'b00;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, div08;
   logic [7:0]  hi8, lo8;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        div0;
   } vec_t;

   vec_t vecs[10];

   muldiv_unit #(.WIDTH(32)) u_dut32 (
      .clock(clk), .reset(rst), .start(start32), .op(op32), .a(a32), .b(b32),
      .cancel(cancel32), .busy(busy32), .done(done32), .div0(div032),
      .hi(hi32), .lo(lo32)
   );

   muldiv_unit #(.WIDTH(8)) u_dut8 (
      .clock(clk), .reset(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .cancel(cancel8), .busy(busy8), .done(done8), .div0(div08),
      .hi(hi8), .lo(lo8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called #1 after a clock edge; returns #1 after the edge following done.
   task automatic run32(input vec_t v, input int idx);
      int k;
      string tag;
      tag = $sformatf("v%0d", idx);
      op32 = v.op; a32 = v.a; b32 = v.b; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      chk({tag, " div0_after_start"}, 64'(div032), 64'(v.div0));
      k = 0;
      while (!done32 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk({tag, " latency"}, 64'(k), v.div0 ? 64'd0 : 64'd33);
      chk({tag, " busy_at_done"}, 64'(busy32), 64'd1);
      chk({tag, " hi"}, 64'(hi32), 64'(v.hi));
      chk({tag, " lo"}, 64'(lo32), 64'(v.lo));
      chk({tag, " div0"}, 64'(div032), 64'(v.div0));
      @(posedge clk); #1;
      chk({tag, " done_pulse_ends"}, 64'(done32), 64'd0);
      chk({tag, " busy_falls"}, 64'(busy32), 64'd0);
   endtask

   task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] eh, input logic [7:0] el, input string tag);
      int k;
      op8 = o; a8 = x; b8 = y; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      k = 0;
      while (!done8 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk({tag, " latency"}, 64'(k), 64'd9);
      chk({tag, " hi"}, 64'(hi8), 64'(eh));
      chk({tag, " lo"}, 64'(lo8), 64'(el));
      @(posedge clk); #1;
      chk({tag, " busy_falls"}, 64'(busy8), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_done;

      vecs[0] = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[2] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      vecs[3] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[4] = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[5] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[6] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[7] = '{DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 1'b0};
      vecs[8] = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
      // Divide by zero right after 7/2: hi/lo keep 1/3
      vecs[9] = '{DIVU,  32'h00000005, 32'h00000000, 32'h00000001, 32'h00000003, 1'b1};

      // Reset state
      #1 rst = 1'b1;
      #2;
      chk("reset hi", 64'(hi32), 64'd0);
      chk("reset lo", 64'(lo32), 64'd0);
      chk("reset busy", 64'(busy32), 64'd0);
      chk("reset done", 64'(done32), 64'd0);
      chk("reset div0", 64'(div032), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run32(vecs[i], i);
      end

      // Next accepted start clears div0
      op32 = MULTU; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      chk("div0 cleared by start", 64'(div032), 64'd0);
      while (!done32) begin
         @(posedge clk); #1;
      end
      chk("3x5 lo", 64'(lo32), 64'd15);
      @(posedge clk); #1;

      // Ignored start while busy, then cancel: no done, outputs unchanged
      op32 = MULTU; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      saw_done = 1'b0;
      for (int e = 1; e <= 11; e++) begin
         @(posedge clk); #1;
         if (done32) saw_done = 1'b1;
         if (e == 4) begin
            op32 = DIVU; a32 = 32'd1; b32 = 32'd0; start32 = 1'b1;
         end
         if (e == 5) start32 = 1'b0;
         if (e == 10) begin
            chk("cancel busy before", 64'(busy32), 64'd1);
            cancel32 = 1'b1;
         end
      end
      cancel32 = 1'b0;
      chk("cancel busy after", 64'(busy32), 64'd0);
      chk("cancel no done", 64'(saw_done), 64'd0);
      chk("cancel hi kept", 64'(hi32), 64'd0);
      chk("cancel lo kept", 64'(lo32), 64'd15);
      chk("ignored start no div0", 64'(div032), 64'd0);
      @(posedge clk); #1;
      chk("idle after cancel done", 64'(done32), 64'd0);

      // Asynchronous reset mid-RUN
      op32 = MULTU; a32 = 32'd100; b32 = 32'd100; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (4) @(posedge clk);
      #4 rst = 1'b1;
      #1;
      chk("async rst hi", 64'(hi32), 64'd0);
      chk("async rst lo", 64'(lo32), 64'd0);
      chk("async rst busy", 64'(busy32), 64'd0);
      chk("async rst done", 64'(done32), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post rst done", 64'(done32), 64'd0);

      // 8-bit instance
      run8(MULT, 8'h80, 8'h80, 8'h40, 8'h00, "w8 mult");
      run8(DIV,  8'h80, 8'hFF, 8'h00, 8'h80, "w8 div ovf");
      run8(DIV,  8'h80, 8'h03, 8'hFE, 8'hD6, "w8 div");
      run8(MULTU, 8'hFF, 8'h02, 8'h01, 8'hFE, "w8 multu");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
